// File: rtl/bus_addr_dec_fsm_pkg.sv
// Shared definitions for the registered bus address decoder: FSM states, error codes,
// and the default location of the slot index field inside s_addr.
package bus_addr_dec_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } dec_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_UNMAP = 2'b01,
    ERR_TO    = 2'b10
  } err_code_t;

  localparam int DEF_IDX_MSB = 31;
  localparam int DEF_IDX_LSB = 29;

endpackage

// File: rtl/bus_dec_timer.sv
// Access watchdog: counts enabled cycles and flags the last permitted one (count == TIMEOUT-1).
// Latency: o_expire is combinational on the current count; no backpressure.
module bus_dec_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LP_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/bus_addr_dec_fsm.sv
// Registered slave decoder with access FSM; slave-timeout error built under `BUS_ADDR_DEC_TIMEOUT_EN.
// Latency: decode-to-cs 1 clk, selected ready passed through combinationally; master holds s_as_ until m_rdy_.
module bus_addr_dec_fsm
  import bus_addr_dec_fsm_pkg::*;
#(
  parameter int                 SLV_NUM = 8,
  parameter int                 IDX_MSB = DEF_IDX_MSB,
  parameter int                 IDX_LSB = DEF_IDX_LSB,
  parameter logic [SLV_NUM-1:0] SLV_MAP = '1,
  parameter int                 TIMEOUT = 255,
  parameter int                 TO_W    = 8
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic [31:0]        s_addr,
  input  logic               s_as_,
  input  logic [SLV_NUM-1:0] slv_rdy_,
  output logic [SLV_NUM-1:0] s_cs_,
  output logic               m_rdy_,
  output logic               m_err,
  output logic [31:0]        err_addr,
  output logic [1:0]         err_code
);

  localparam int IW = IDX_MSB - IDX_LSB + 1;

  dec_state_t         r_state;
  logic [SLV_NUM-1:0] r_cs_n;
  logic [31:0]        r_err_addr;
  err_code_t          r_err_code;

  logic [IW-1:0]      w_idx;
  logic               w_hit;
  logic [SLV_NUM-1:0] w_dec_n;
  logic               w_sel_rdy_n;
  logic               w_done;
  logic               w_expire;
  logic [31:0]        w_to_addr;

  assign w_idx = s_addr[IDX_MSB:IDX_LSB];

  // Indices beyond SLV_NUM never match any slot, so they fall through as unmapped.
  always_comb begin
    w_hit   = 1'b0;
    w_dec_n = '1;
    for (int i = 0; i < SLV_NUM; i++) begin
      if (w_idx == IW'(i) && SLV_MAP[i]) begin
        w_hit      = 1'b1;
        w_dec_n[i] = 1'b0;
      end
    end
  end

  // The registered chip selects double as the ready-mux select: only the low cs lane passes.
  assign w_sel_rdy_n = &(slv_rdy_ | r_cs_n);
  assign w_done      = (r_state == ST_ACCESS) && !s_as_ && !w_sel_rdy_n;

`ifdef BUS_ADDR_DEC_TIMEOUT_EN
  logic [31:0] r_to_addr;

  bus_dec_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (clk),
    .i_reset_n (reset_),
    .i_clr     (r_state != ST_ACCESS),
    .i_en      (r_state == ST_ACCESS),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_to_addr <= '0;
    end else if (r_state == ST_IDLE && !s_as_) begin
      r_to_addr <= s_addr;
    end
  end

  assign w_to_addr = r_to_addr;
`else
  logic w_unused_cfg;

  assign w_expire     = 1'b0;
  assign w_to_addr    = s_addr;
  assign w_unused_cfg = (TIMEOUT == 0) ^ (TO_W == 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state    <= ST_IDLE;
      r_cs_n     <= '1;
      r_err_addr <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cs_n <= '1;
          if (!s_as_) begin
            if (w_hit) begin
              r_state <= ST_ACCESS;
              r_cs_n  <= w_dec_n;
            end else begin
              r_state    <= ST_ERR;
              r_err_addr <= s_addr;
              r_err_code <= ERR_UNMAP;
            end
          end
        end
        ST_ACCESS: begin
          // Completion and master abort both beat an expiry landing on the same cycle.
          if (s_as_ || !w_sel_rdy_n) begin
            r_state <= ST_IDLE;
            r_cs_n  <= '1;
          end else if (w_expire) begin
            r_state    <= ST_ERR;
            r_cs_n     <= '1;
            r_err_addr <= w_to_addr;
            r_err_code <= ERR_TO;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
          r_cs_n  <= '1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= '1;
        end
      endcase
    end
  end

  assign s_cs_    = r_cs_n;
  assign m_rdy_   = !(w_done || (r_state == ST_ERR));
  assign m_err    = (r_state == ST_ERR);
  assign err_addr = r_err_addr;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_bus_addr_dec_fsm.sv
// Directed bench for bus_addr_dec_fsm with a completion scoreboard; timeout steps follow `BUS_ADDR_DEC_TIMEOUT_EN.
module tb_bus_addr_dec_fsm;

  logic        clk = 1'b0;
  logic        reset_;
  logic [31:0] s_addr;
  logic        s_as_;
  logic [7:0]  slv_rdy_;
  logic [7:0]  s_cs_;
  logic        m_rdy_;
  logic        m_err;
  logic [31:0] err_addr;
  logic [1:0]  err_code;

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_addr_dec_fsm #(
    .SLV_NUM (8),
    .IDX_MSB (31),
    .IDX_LSB (29),
    .SLV_MAP (8'h7F),
    .TIMEOUT (4),
    .TO_W    (8)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .s_addr   (s_addr),
    .s_as_    (s_as_),
    .slv_rdy_ (slv_rdy_),
    .s_cs_    (s_cs_),
    .m_rdy_   (m_rdy_),
    .m_err    (m_err),
    .err_addr (err_addr),
    .err_code (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic e, input logic [1:0] c, input logic [31:0] a);
    exp_t x;
    x.err  = e;
    x.code = c;
    x.addr = a;
    exp_q.push_back(x);
  endtask

  // Every master-visible ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (reset_ === 1'b1 && m_rdy_ === 1'b0) begin
      chk("sb_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_err", 32'(m_err), 32'(e.err));
        if (e.err) begin
          chk("sb_code", 32'(err_code), 32'(e.code));
          chk("sb_addr", err_addr, e.addr);
        end
      end
    end
  end

  initial begin
    reset_   = 1'b0;
    s_as_    = 1'b1;
    s_addr   = '0;
    slv_rdy_ = '1;
    tick();
    tick();
    chk("rst_cs", 32'(s_cs_), 32'h0000_00FF);
    chk("rst_rdy", 32'(m_rdy_), 32'd1);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_eaddr", err_addr, 32'd0);
    reset_ = 1'b1;

    // Normal access to slot 2 with unrelated slave asserting ready
    s_addr = 32'h4000_0010;
    s_as_  = 1'b0;
    push(1'b0, 2'b00, 32'h0);
    tick();
    chk("t2_cs", 32'(s_cs_), 32'h0000_00FB);
    chk("t2_wait_rdy", 32'(m_rdy_), 32'd1);
    slv_rdy_[5] = 1'b0;
    #1;
    chk("t2_other_ignored", 32'(m_rdy_), 32'd1);
    tick();
    chk("t2_cs_hold", 32'(s_cs_), 32'h0000_00FB);
    s_addr = 32'hE000_0000;
    tick();
    chk("t2_addr_latched", 32'(s_cs_), 32'h0000_00FB);
    slv_rdy_[2] = 1'b0;
    #1;
    chk("t2_rdy", 32'(m_rdy_), 32'd0);
    chk("t2_noerr", 32'(m_err), 32'd0);
    tick();
    s_as_    = 1'b1;
    slv_rdy_ = '1;
    chk("t2_release", 32'(s_cs_), 32'h0000_00FF);
    chk("t2_idle_rdy", 32'(m_rdy_), 32'd1);

    // Unpopulated slot 7
    s_addr = 32'hE000_0000;
    s_as_  = 1'b0;
    push(1'b1, 2'b01, 32'hE000_0000);
    tick();
    s_as_ = 1'b1;
    chk("t3_cs", 32'(s_cs_), 32'h0000_00FF);
    chk("t3_rdy", 32'(m_rdy_), 32'd0);
    chk("t3_err", 32'(m_err), 32'd1);
    chk("t3_code", 32'(err_code), 32'd1);
    chk("t3_addr", err_addr, 32'hE000_0000);
    tick();
    chk("t3_one_cycle_err", 32'(m_err), 32'd0);
    chk("t3_one_cycle_rdy", 32'(m_rdy_), 32'd1);
    chk("t3_code_hold", 32'(err_code), 32'd1);

    // Back-to-back: slot 6 completes at once, slot 3 follows after one IDLE cycle
    s_addr = 32'hC000_0000;
    s_as_  = 1'b0;
    push(1'b0, 2'b00, 32'h0);
    tick();
    chk("bb_cs6", 32'(s_cs_), 32'h0000_00BF);
    slv_rdy_[6] = 1'b0;
    #1;
    chk("bb_rdy6", 32'(m_rdy_), 32'd0);
    tick();
    slv_rdy_ = '1;
    s_addr   = 32'h6000_0000;
    chk("bb_gap", 32'(s_cs_), 32'h0000_00FF);
    tick();
    chk("bb_cs3", 32'(s_cs_), 32'h0000_00F7);

    // Master abort of the slot 3 access
    tick();
    s_as_ = 1'b1;
    #1;
    chk("ab_rdy", 32'(m_rdy_), 32'd1);
    tick();
    chk("ab_release", 32'(s_cs_), 32'h0000_00FF);
    chk("ab_rdy_idle", 32'(m_rdy_), 32'd1);

    // Reset in the middle of a slot 1 access
    s_addr = 32'h2000_0000;
    s_as_  = 1'b0;
    tick();
    chk("rs_cs", 32'(s_cs_), 32'h0000_00FD);
    reset_ = 1'b0;
    tick();
    chk("rs_cs_rel", 32'(s_cs_), 32'h0000_00FF);
    chk("rs_rdy", 32'(m_rdy_), 32'd1);
    chk("rs_err", 32'(m_err), 32'd0);
    chk("rs_code", 32'(err_code), 32'd0);
    chk("rs_eaddr", err_addr, 32'd0);
    reset_ = 1'b1;
    s_as_  = 1'b1;
    tick();

`ifdef BUS_ADDR_DEC_TIMEOUT_EN
    // Silent slave 1 runs into the 4-cycle timeout; address changes mid-access are ignored
    s_addr = 32'h2000_0000;
    s_as_  = 1'b0;
    push(1'b1, 2'b10, 32'h2000_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_cs", 32'(s_cs_), 32'h0000_00FD);
      if (i == 1) s_addr = 32'hE000_0000;
    end
    tick();
    chk("t4_cs_rel", 32'(s_cs_), 32'h0000_00FF);
    chk("t4_rdy", 32'(m_rdy_), 32'd0);
    chk("t4_err", 32'(m_err), 32'd1);
    chk("t4_code", 32'(err_code), 32'd2);
    chk("t4_addr", err_addr, 32'h2000_0000);
    s_as_ = 1'b1;
    tick();
    chk("t4_err_clear", 32'(m_err), 32'd0);

    // Ready on the last permitted cycle beats the timeout
    s_addr = 32'h8000_0000;
    s_as_  = 1'b0;
    push(1'b0, 2'b00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_cs", 32'(s_cs_), 32'h0000_00EF);
    end
    slv_rdy_[4] = 1'b0;
    #1;
    chk("t5_rdy", 32'(m_rdy_), 32'd0);
    chk("t5_noerr", 32'(m_err), 32'd0);
    tick();
    s_as_    = 1'b1;
    slv_rdy_ = '1;
    chk("t5_cs_rel", 32'(s_cs_), 32'h0000_00FF);
    chk("t5_code_hold", 32'(err_code), 32'd2);
    chk("t5_err_idle", 32'(m_err), 32'd0);
`else
    // Without the watchdog a slow slave keeps its select indefinitely
    s_addr = 32'h2000_0000;
    s_as_  = 1'b0;
    push(1'b0, 2'b00, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    chk("slow_cs", 32'(s_cs_), 32'h0000_00FD);
    chk("slow_noerr", 32'(m_err), 32'd0);
    slv_rdy_[1] = 1'b0;
    #1;
    chk("slow_rdy", 32'(m_rdy_), 32'd0);
    tick();
    s_as_    = 1'b1;
    slv_rdy_ = '1;
    chk("slow_cs_rel", 32'(s_cs_), 32'h0000_00FF);
    chk("slow_code", 32'(err_code), 32'd0);
`endif

    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
